// File: rtl/cpu_phase_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_phase_sequencer
//
// Multi-cycle control sequencer for the LEGv8 datapath. From a single clock it
// produces one-hot phase enables for fetch, decode, register read, execute,
// data memory and register write-back. Phases the current opcode does not need
// are skipped, and the MEM phase handshakes with data memory.
//
// Optional feature macro: SEQ_PERF_CNT_EN
//   defined   -> instr_count counts retired instructions (wraps, cleared by rst)
//   undefined -> instr_count is tied to zero
//
// Parameters:
//   MEM_TIMEOUT  max MEM cycles waiting for mem_ready before the access aborts
//   OPCODE_W     width of the opcode field instr[31:21]
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        level; leaves IDLE and begins fetching
//   halt         level; sampled on the retire cycle, stops after that instr
//   opcode       instr[31:21], valid during DECODE
//   mem_ready    data memory access complete (only looked at in MEM)
//   fetch_en     FETCH phase enable
//   decode_en    DECODE phase enable
//   read_en      register file read strobe (READ)
//   exec_en      ALU / branch evaluation (EXEC)
//   mem_en       data memory request, held until mem_ready (MEM)
//   write_en     register file write strobe (WB)
//   pc_en        PC update pulse, marks instruction retire
//   busy         high in every state except IDLE
//   illegal_op   sticky, unrecognised opcode seen in DECODE
//   mem_timeout  sticky, MEM waited MEM_TIMEOUT cycles without mem_ready
//   instr_count  retired-instruction count
// -----------------------------------------------------------------------------
module cpu_phase_sequencer #(
   parameter int unsigned MEM_TIMEOUT = 8,
   parameter int unsigned OPCODE_W    = 11
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                halt,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                fetch_en,
   output logic                decode_en,
   output logic                read_en,
   output logic                exec_en,
   output logic                mem_en,
   output logic                write_en,
   output logic                pc_en,
   output logic                busy,
   output logic                illegal_op,
   output logic                mem_timeout,
   output logic [31:0]         instr_count
);

   localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_READ,
      S_EXEC,
      S_MEM,
      S_WB
   } state_t;

   typedef enum logic [2:0] {
      C_NONE,
      C_LOAD,
      C_STORE,
      C_CBZ,
      C_B,
      C_RTYPE,
      C_ILLEGAL
   } op_class_t;

   state_t    state, state_nx;
   op_class_t op_class, dec_class;
   logic [TW-1:0] tmo_cnt;
   logic      retire;
   logic      set_illegal;
   logic      set_timeout;

   function automatic op_class_t classify(input logic [OPCODE_W-1:0] op);
      op_class_t c;
      c = C_ILLEGAL;
      if (op == OPCODE_W'(11'h7C2))
         c = C_LOAD;
      else if (op == OPCODE_W'(11'h7C0))
         c = C_STORE;
      else if (op >= OPCODE_W'(11'h5A0) && op <= OPCODE_W'(11'h5A7))
         c = C_CBZ;
      else if (op >= OPCODE_W'(11'h0A0) && op <= OPCODE_W'(11'h0BF))
         c = C_B;
      else if (op == OPCODE_W'(11'h458) || op == OPCODE_W'(11'h658) ||
               op == OPCODE_W'(11'h450) || op == OPCODE_W'(11'h550))
         c = C_RTYPE;
      return c;
   endfunction

   assign dec_class = classify(opcode);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   // Next-state and phase outputs
   always_comb begin
      state_nx    = state;
      fetch_en    = 1'b0;
      decode_en   = 1'b0;
      read_en     = 1'b0;
      exec_en     = 1'b0;
      mem_en      = 1'b0;
      write_en    = 1'b0;
      retire      = 1'b0;
      set_illegal = 1'b0;
      set_timeout = 1'b0;
      case (state)
         S_IDLE: begin
            if (start)
               state_nx = S_FETCH;
         end
         S_FETCH: begin
            fetch_en = 1'b1;
            state_nx = S_DECODE;
         end
         S_DECODE: begin
            decode_en = 1'b1;
            if (dec_class == C_ILLEGAL) begin
               set_illegal = 1'b1;
               state_nx    = S_IDLE;
            end else begin
               state_nx = S_READ;
            end
         end
         S_READ: begin
            read_en  = 1'b1;
            state_nx = S_EXEC;
         end
         S_EXEC: begin
            exec_en = 1'b1;
            case (op_class)
               C_LOAD, C_STORE: state_nx = S_MEM;
               C_RTYPE:         state_nx = S_WB;
               C_B, C_CBZ:      retire   = 1'b1;
               default:         state_nx = S_IDLE;
            endcase
         end
         S_MEM: begin
            mem_en = 1'b1;
            if (mem_ready) begin
               if (op_class == C_LOAD)
                  state_nx = S_WB;
               else
                  retire = 1'b1;
            end else if (tmo_cnt == TW'(MEM_TIMEOUT - 1)) begin
               // this is the MEM_TIMEOUT-th MEM cycle without a response
               set_timeout = 1'b1;
               state_nx    = S_IDLE;
            end
         end
         S_WB: begin
            write_en = 1'b1;
            retire   = 1'b1;
         end
         default: state_nx = S_IDLE;
      endcase
      // halt has priority over everything on the retire cycle
      if (retire)
         state_nx = halt ? S_IDLE : S_FETCH;
   end

   assign pc_en = retire;
   assign busy  = (state != S_IDLE);

   // Opcode class captured on the DECODE cycle, used by EXEC and MEM
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         op_class <= C_NONE;
      else if (state == S_DECODE)
         op_class <= dec_class;
   end

   // MEM wait counter, zero whenever the next cycle is not another MEM cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tmo_cnt <= '0;
      else if (state == S_MEM && state_nx == S_MEM)
         tmo_cnt <= tmo_cnt + TW'(1);
      else
         tmo_cnt <= '0;
   end

   // Sticky error flags, cleared when a new run starts from IDLE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         illegal_op  <= 1'b0;
         mem_timeout <= 1'b0;
      end else if (state == S_IDLE && start) begin
         illegal_op  <= 1'b0;
         mem_timeout <= 1'b0;
      end else begin
         if (set_illegal)
            illegal_op <= 1'b1;
         if (set_timeout)
            mem_timeout <= 1'b1;
      end
   end

`ifdef SEQ_PERF_CNT_EN
   logic [31:0] count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count_q <= '0;
      else if (retire)
         count_q <= count_q + 32'd1;
   end

   assign instr_count = count_q;
`else
   assign instr_count = '0;
`endif

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_phase_sequencer
//
// Directed plus randomized bench for cpu_phase_sequencer. For every instruction
// the expected phase trace is built from the opcode class, the memory wait and
// the halt choice; each clock cycle the enables, pc_en, busy, sticky flags and
// instr_count are compared against that trace.
// -----------------------------------------------------------------------------
module tb_cpu_phase_sequencer;

   localparam int unsigned TO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        halt = 1'b0;
   logic        mem_ready = 1'b0;
   logic [10:0] opcode = '0;
   logic        fetch_en, decode_en, read_en, exec_en, mem_en, write_en;
   logic        pc_en, busy, illegal_op, mem_timeout;
   logic [31:0] instr_count;

   int          n_cmp = 0;
   int          n_fail = 0;
   bit          exp_ill = 1'b0;
   bit          exp_to = 1'b0;
   logic [31:0] exp_count = '0;
   bit          in_idle = 1'b1;

   cpu_phase_sequencer #(
      .MEM_TIMEOUT (TO),
      .OPCODE_W    (11)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .halt        (halt),
      .opcode      (opcode),
      .mem_ready   (mem_ready),
      .fetch_en    (fetch_en),
      .decode_en   (decode_en),
      .read_en     (read_en),
      .exec_en     (exec_en),
      .mem_en      (mem_en),
      .write_en    (write_en),
      .pc_en       (pc_en),
      .busy        (busy),
      .illegal_op  (illegal_op),
      .mem_timeout (mem_timeout),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   // 0 illegal, 1 load, 2 store, 3 cbz, 4 b, 5 rtype
   function automatic int ref_class(input logic [10:0] op);
      int v;
      v = int'(op);
      if (v == 'h7C2) return 1;
      if (v == 'h7C0) return 2;
      if (v >= 'h5A0 && v <= 'h5A7) return 3;
      if (v >= 'h0A0 && v <= 'h0BF) return 4;
      if (v == 'h458 || v == 'h658 || v == 'h450 || v == 'h550) return 5;
      return 0;
   endfunction

   // Phase numbers: 0 idle, 1 fetch, 2 decode, 3 read, 4 exec, 5 mem, 6 wb
   function automatic logic [7:0] ev(input int ph, input bit pc);
      logic [5:0] oh;
      oh = (ph == 0) ? 6'b000000 : (6'b100000 >> (ph - 1));
      return {oh, pc, (ph != 0)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_cycle(input string tag, input int ph, input bit pc);
      logic [7:0] obs;
      obs = {fetch_en, decode_en, read_en, exec_en, mem_en, write_en, pc_en, busy};
      chk({tag, "/enables"}, {24'b0, obs}, {24'b0, ev(ph, pc)});
      chk({tag, "/flags"}, {30'b0, illegal_op, mem_timeout}, {30'b0, exp_ill, exp_to});
`ifdef SEQ_PERF_CNT_EN
      chk({tag, "/count"}, instr_count, exp_count);
`else
      chk({tag, "/count"}, instr_count, 32'd0);
`endif
   endtask

   // One IDLE cycle with start raised; the run begins on the next edge
   task automatic do_start(input logic [10:0] op);
      @(negedge clk);
      start     = 1'b1;
      opcode    = op;
      halt      = 1'($urandom_range(0, 1));
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      check_cycle("idle_start", 0, 1'b0);
      exp_ill = 1'b0;
      exp_to  = 1'b0;
      in_idle = 1'b0;
   endtask

   // Runs one instruction from its FETCH cycle; w = MEM cycles before mem_ready
   task automatic run_instr(input logic [10:0] op, input int w, input bit hlt);
      int  ph[$];
      int  retire_idx;
      int  cls;
      int  mcount;
      int  nmem;
      bit  tmo;
      cls        = ref_class(op);
      retire_idx = -1;
      tmo        = 1'b0;
      mcount     = 0;
      ph.push_back(1);
      ph.push_back(2);
      if (cls != 0) begin
         ph.push_back(3);
         ph.push_back(4);
         if (cls == 5) begin
            ph.push_back(6);
            retire_idx = 4;
         end else if (cls == 3 || cls == 4) begin
            retire_idx = 3;
         end else begin
            tmo  = (w >= int'(TO));
            nmem = tmo ? int'(TO) : w + 1;
            for (int k = 0; k < nmem; k++) ph.push_back(5);
            if (!tmo) begin
               if (cls == 1) ph.push_back(6);
               retire_idx = ph.size() - 1;
            end
         end
      end
      for (int i = 0; i < ph.size(); i++) begin
         @(negedge clk);
         if (i == 0) opcode = op;
         start = 1'($urandom_range(0, 1));
         halt  = (i == retire_idx) ? hlt : 1'($urandom_range(0, 1));
         if (ph[i] == 5) begin
            mem_ready = !tmo && (mcount == w);
            mcount++;
         end else begin
            mem_ready = 1'($urandom_range(0, 1));
         end
         #1;
         check_cycle($sformatf("op%03h_c%0d", op, i), ph[i], (i == retire_idx));
         if (i == retire_idx) exp_count = exp_count + 32'd1;
      end
      if (cls == 0) exp_ill = 1'b1;
      if (tmo) exp_to = 1'b1;
      if (retire_idx < 0 || hlt) begin
         @(negedge clk);
         start     = 1'b0;
         halt      = 1'($urandom_range(0, 1));
         mem_ready = 1'($urandom_range(0, 1));
         #1;
         check_cycle($sformatf("op%03h_idle", op), 0, 1'b0);
         in_idle = 1'b1;
      end else begin
         in_idle = 1'b0;
      end
   endtask

   function automatic logic [10:0] rand_op();
      logic [10:0] op;
      op = 11'h000;
      case ($urandom_range(0, 5))
         0: begin
            for (int k = 0; k < 64; k++) begin
               op = 11'($urandom);
               if (ref_class(op) == 0) break;
            end
            if (ref_class(op) != 0) op = 11'h000;
         end
         1: op = 11'h7C2;
         2: op = 11'h7C0;
         3: op = 11'h5A0 + 11'($urandom_range(0, 7));
         4: op = 11'h0A0 + 11'($urandom_range(0, 31));
         default: begin
            case ($urandom_range(0, 3))
               0: op = 11'h458;
               1: op = 11'h658;
               2: op = 11'h450;
               default: op = 11'h550;
            endcase
         end
      endcase
      return op;
   endfunction

   initial begin
      logic [10:0] op;
      int          w;
      bit          h;
      int          mem_ph[$];

      // Reset state
      @(negedge clk);
      #1;
      check_cycle("reset", 0, 1'b0);
      rst = 1'b0;

      // ADD then LOAD with 3 MEM cycles, STORE, CBZ, B (halt)
      do_start(11'h458);
      run_instr(11'h458, 0, 1'b0);
      run_instr(11'h7C2, 2, 1'b0);
      run_instr(11'h7C0, 0, 1'b0);
      run_instr(11'h5A7, 0, 1'b0);
      run_instr(11'h0A0, 0, 1'b1);

      // LOAD that never sees mem_ready
      do_start(11'h7C2);
      run_instr(11'h7C2, TO + 3, 1'b0);

      // Illegal opcode; the following start clears the flag
      do_start(11'h000);
      run_instr(11'h000, 0, 1'b0);
      do_start(11'h550);
      run_instr(11'h550, 0, 1'b0);
      run_instr(11'h7C2, TO - 1, 1'b1);

      // Randomized instruction stream
      for (int k = 0; k < 60; k++) begin
         op = rand_op();
         w  = $urandom_range(0, 10);
         h  = ($urandom_range(0, 3) == 0);
         if (in_idle) do_start(op);
         run_instr(op, w, h);
      end
      if (!in_idle) run_instr(11'h458, 0, 1'b1);

      // Asynchronous reset in the middle of a MEM wait
      do_start(11'h7C2);
      mem_ph = {1, 2, 3, 4, 5, 5};
      for (int i = 0; i < mem_ph.size(); i++) begin
         @(negedge clk);
         start     = 1'b0;
         halt      = 1'b0;
         mem_ready = (mem_ph[i] == 5) ? 1'b0 : 1'($urandom_range(0, 1));
         #1;
         check_cycle($sformatf("rstload_c%0d", i), mem_ph[i], 1'b0);
      end
      #1;
      rst       = 1'b1;
      exp_count = '0;
      exp_ill   = 1'b0;
      exp_to    = 1'b0;
      #1;
      check_cycle("rst_async", 0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_cycle("rst_release", 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_phase_sequencer.md
Name: cpu_phase_sequencer

Overview:
- Multi-cycle control sequencer for the LEGv8 datapath.
- Replaces the delayed-clock chain (clk_plus_N taps) that currently staggers fetch, decode, register read and register write.
- Generates one-hot phase enables for iFetch, iDecode (decode, register read, register write), execute and memory from a single clock.
- Skips phases the current opcode does not need, and handshakes with data memory.

Parameters:
- MEM_TIMEOUT, 8: max cycles spent in MEM waiting for mem_ready before abort.
- OPCODE_W, 11: width of the opcode field, instr[31:21].

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  level; begin execution from IDLE.
- halt  in  1  level; sampled on the retire cycle; stop after the current instruction.
- opcode  in  OPCODE_W  instr[31:21] from iFetch; valid during DECODE.
- mem_ready  in  1  data memory access complete.
- fetch_en  out  1  iFetch latches instruction.
- decode_en  out  1  iDecode control and sign-extend update.
- read_en  out  1  register file read strobe.
- exec_en  out  1  ALU / branch-target evaluation.
- mem_en  out  1  data memory request; held until mem_ready.
- write_en  out  1  register file write strobe.
- pc_en  out  1  PC update pulse; marks instruction retire.
- busy  out  1  high in any state except IDLE.
- illegal_op  out  1  sticky; unrecognised opcode.
- mem_timeout  out  1  sticky; MEM exceeded MEM_TIMEOUT.
- instr_count  out  32  retired-instruction count (see Optional Feature).

Behaviour:
- States: IDLE, FETCH, DECODE, READ, EXEC, MEM, WB.
- Moore outputs: each enable is high exactly while in its state. fetch_en=FETCH, decode_en=DECODE, read_en=READ, exec_en=EXEC, mem_en=MEM, write_en=WB.
- Reset (async, rst=1):
  - state=IDLE.
  - All outputs 0, including illegal_op, mem_timeout and instr_count.
  - Internal timeout counter and opcode class cleared.
  - Reset mid-instruction aborts it immediately; no pc_en is issued.
- IDLE: start=1 -> FETCH next cycle. Sticky flags are cleared on that same transition.
- FETCH -> DECODE -> READ, one cycle each.
- Opcode class is decoded combinationally and registered on the DECODE cycle:
  - LOAD: 0x7C2.
  - STORE: 0x7C0.
  - CBZ: 0x5A0-0x5A7.
  - B: 0x0A0-0x0BF.
  - RTYPE: 0x458, 0x658, 0x450, 0x550.
  - Anything else: illegal. Set illegal_op=1 and go to IDLE after DECODE (READ is never entered). No pc_en.
- READ -> EXEC.
- EXEC, by class:
  - LOAD and STORE go to MEM.
  - RTYPE goes to WB.
  - B and CBZ retire in EXEC: pc_en=1 in EXEC.
- MEM:
  - mem_en held high; timeout counter increments each MEM cycle.
  - mem_ready=1 in the first MEM cycle gives a one-cycle MEM.
  - On mem_ready: LOAD goes to WB; STORE retires in MEM, with pc_en=1 in that cycle.
  - Counter reaching MEM_TIMEOUT without mem_ready: set mem_timeout=1, go to IDLE, no pc_en.
  - mem_ready outside MEM is ignored.
- WB: pc_en=1; this is the retire cycle.
- Retire cycle (pc_en=1): halt=1 goes to IDLE; otherwise go to FETCH.
  - halt and start both high on a retire cycle: halt wins.
  - start is ignored outside IDLE.
- Latency from FETCH entry to retire:
  - RTYPE: 5 cycles.
  - B/CBZ: 4 cycles.
  - STORE: 5 cycles, plus wait cycles.
  - LOAD: 6 cycles, plus wait cycles.
- Exactly one enable is high at any time; all are low in IDLE.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- Defined: instr_count increments by 1 on every pc_en cycle. It wraps from 0xFFFFFFFF to 0 and clears on rst only.
- Undefined: instr_count is tied to 0 and no counter logic is generated.

Test Plan:
- Reset then start=1 for one cycle, opcode=0x458 (ADD 8B09026A), halt=0 -> FETCH, DECODE, READ, EXEC, WB on cycles 1-5; pc_en on cycle 5; FETCH on cycle 6.
- LOAD 0x7C2 (F84402C9), mem_ready asserted on the 3rd MEM cycle -> mem_en high for 3 cycles, then WB, pc_en; 8 cycles FETCH-to-retire.
- STORE 0x7C0 (F80602CB), then CBZ 0x5A7 (B4FFFF6B), then B 0x0A0 (14000040) -> pc_en in MEM, EXEC, EXEC respectively; write_en never asserted.
- LOAD with mem_ready held 0 and MEM_TIMEOUT=8 -> mem_timeout=1 after the 8th MEM cycle, IDLE, busy=0, no pc_en.
- opcode=0x000 -> illegal_op=1 after DECODE, IDLE; a new start clears illegal_op.
- rst pulsed during MEM -> all outputs 0 immediately (async). With SEQ_PERF_CNT_EN, 10 retired instructions give instr_count=10; rst clears it to 0.
